// File: rtl/hilo_unit_pkg.sv
// Shared types and constants for the HI/LO multiply control stage.
package hilo_unit_pkg;

   localparam int unsigned WORD_W          = 32;
   localparam int unsigned DWORD_W         = 64;
   localparam int unsigned CNT_W           = 4;
   localparam int unsigned MUL_LAT_DEFAULT = 2;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } hilo_state_e;

endpackage

// File: rtl/hilo_lat_counter.sv
// Settle-window down-counter: loadable, decrements to zero, flags zero.
module hilo_lat_counter
   import hilo_unit_pkg::*;
#(
   parameter int unsigned W = CNT_W
) (
   input  logic         clock,
   input  logic         clear,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic         zero
);

   always_ff @(posedge clock) begin
      if (clear) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register stage: launches operands to the Booth multiplier, waits
// MUL_LAT cycles, captures the product, and services MTHI/MTLO writes.
module hilo_unit
   import hilo_unit_pkg::*;
#(
   parameter int unsigned MUL_LAT = MUL_LAT_DEFAULT
) (
   input  logic              clock,
   input  logic              clear,
   input  logic              start,
   input  logic [WORD_W-1:0] a,
   input  logic [WORD_W-1:0] b,
   output logic [WORD_W-1:0] mul_x,
   output logic [WORD_W-1:0] mul_y,
   input  logic [WORD_W-1:0] prod_lo,
   input  logic [WORD_W-1:0] prod_hi,
   input  logic              mthi,
   input  logic              mtlo,
   input  logic [WORD_W-1:0] wdata,
   output logic              busy,
   output logic              done,
   output logic [WORD_W-1:0] hi,
   output logic [WORD_W-1:0] lo,
   output hilo_state_e       fsm_state
);

   logic             cnt_load;
   logic             cnt_dec;
   logic             cnt_zero;
   logic [CNT_W-1:0] cnt;

   // Counter is loaded on the accepting edge and runs only while in RUN.
   assign cnt_load = (fsm_state == IDLE) && start;
   assign cnt_dec  = (fsm_state == RUN) && !cnt_zero;

   hilo_lat_counter #(
      .W(CNT_W)
   ) u_lat_counter (
      .clock    (clock),
      .clear    (clear),
      .load     (cnt_load),
      .load_val (CNT_W'(MUL_LAT - 1)),
      .dec      (cnt_dec),
      .count    (cnt),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clock) begin
      if (clear) begin
         fsm_state <= IDLE;
         mul_x     <= '0;
         mul_y     <= '0;
         hi        <= '0;
         lo        <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (fsm_state)
            IDLE: begin
               if (mthi) hi <= wdata;
               if (mtlo) lo <= wdata;
               if (start) begin
                  mul_x     <= a;
                  mul_y     <= b;
                  busy      <= 1'b1;
                  fsm_state <= RUN;
               end
            end
            RUN: begin
               // mthi/mtlo/start are ignored here; the product always wins.
               if (cnt_zero) begin
                  hi        <= prod_hi;
                  lo        <= prod_lo;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  fsm_state <= IDLE;
               end
            end
            default: fsm_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit: MUL_LAT=2 instance for the main sequences,
// MUL_LAT=4 instance for the mid-run clear sequence.
module tb_hilo_unit;
   import hilo_unit_pkg::*;

   logic        clock = 1'b0;
   logic [31:0] a, b, wdata;

   logic        clear2, start2, mthi2, mtlo2;
   logic [31:0] mul_x2, mul_y2, hi2, lo2;
   logic        busy2, done2;
   hilo_state_e st2;
   logic [63:0] p2;

   logic        clear4, start4, mthi4, mtlo4;
   logic [31:0] mul_x4, mul_y4, hi4, lo4;
   logic        busy4, done4;
   hilo_state_e st4;
   logic [63:0] p4;

   int tests  = 0;
   int errors = 0;

   always #5 clock = ~clock;

   // Behavioural signed multiplier models feeding each instance.
   assign p2 = {{32{mul_x2[31]}}, mul_x2} * {{32{mul_y2[31]}}, mul_y2};
   assign p4 = {{32{mul_x4[31]}}, mul_x4} * {{32{mul_y4[31]}}, mul_y4};

   hilo_unit #(.MUL_LAT(2)) u_dut2 (
      .clock(clock), .clear(clear2), .start(start2), .a(a), .b(b),
      .mul_x(mul_x2), .mul_y(mul_y2), .prod_lo(p2[31:0]), .prod_hi(p2[63:32]),
      .mthi(mthi2), .mtlo(mtlo2), .wdata(wdata), .busy(busy2), .done(done2),
      .hi(hi2), .lo(lo2), .fsm_state(st2)
   );

   hilo_unit #(.MUL_LAT(4)) u_dut4 (
      .clock(clock), .clear(clear4), .start(start4), .a(a), .b(b),
      .mul_x(mul_x4), .mul_y(mul_y4), .prod_lo(p4[31:0]), .prod_hi(p4[63:32]),
      .mthi(mthi4), .mtlo(mtlo4), .wdata(wdata), .busy(busy4), .done(done4),
      .hi(hi4), .lo(lo4), .fsm_state(st4)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      // Garbage on every input with clear asserted; clear must dominate.
      a = 32'hCAFEBABE; b = 32'h0BADF00D; wdata = 32'hFFFF0000;
      clear2 = 1'b1; start2 = 1'b1; mthi2 = 1'b1; mtlo2 = 1'b1;
      clear4 = 1'b1; start4 = 1'b1; mthi4 = 1'b1; mtlo4 = 1'b1;
      step();
      clear2 = 1'b0; start2 = 1'b0; mthi2 = 1'b0; mtlo2 = 1'b0;
      clear4 = 1'b0; start4 = 1'b0; mthi4 = 1'b0; mtlo4 = 1'b0;
      check("rst_hi", hi2, 32'h0);
      check("rst_lo", lo2, 32'h0);
      check("rst_mul_x", mul_x2, 32'h0);
      check("rst_mul_y", mul_y2, 32'h0);
      check("rst_busy", 32'(busy2), 32'h0);
      check("rst_done", 32'(done2), 32'h0);
      check("rst_state", 32'(st2), 32'(IDLE));

      // 7 * -3 = -21
      a = 32'd7; b = 32'hFFFFFFFD; start2 = 1'b1;
      step();
      start2 = 1'b0;
      check("m1_busy_e0", 32'(busy2), 32'h1);
      check("m1_done_e0", 32'(done2), 32'h0);
      check("m1_mul_x", mul_x2, 32'd7);
      check("m1_mul_y", mul_y2, 32'hFFFFFFFD);
      check("m1_state", 32'(st2), 32'(RUN));
      step();
      check("m1_busy_e1", 32'(busy2), 32'h1);
      check("m1_done_e1", 32'(done2), 32'h0);
      step();
      check("m1_hi", hi2, 32'hFFFFFFFF);
      check("m1_lo", lo2, 32'hFFFFFFEB);
      check("m1_done", 32'(done2), 32'h1);
      check("m1_busy_cap", 32'(busy2), 32'h0);
      step();
      check("m1_done_pulse", 32'(done2), 32'h0);
      check("m1_hi_hold", hi2, 32'hFFFFFFFF);

      // Back-to-back: 0x7FFFFFFF*2, then -1*-1 issued in the done cycle.
      a = 32'h7FFFFFFF; b = 32'd2; start2 = 1'b1;
      step();
      start2 = 1'b0;
      step();
      step();
      check("b2b1_done", 32'(done2), 32'h1);
      check("b2b1_hi", hi2, 32'h00000000);
      check("b2b1_lo", lo2, 32'hFFFFFFFE);
      a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start2 = 1'b1;
      step();
      start2 = 1'b0;
      check("b2b2_busy", 32'(busy2), 32'h1);
      check("b2b2_mul_x", mul_x2, 32'hFFFFFFFF);
      check("b2b2_done_clr", 32'(done2), 32'h0);
      step();
      step();
      check("b2b2_done", 32'(done2), 32'h1);
      check("b2b2_hi", hi2, 32'h0);
      check("b2b2_lo", lo2, 32'h1);

      // Idle MTHI, then MTHI and start while busy are ignored.
      wdata = 32'h12345678; mthi2 = 1'b1;
      step();
      mthi2 = 1'b0;
      check("mthi_hi", hi2, 32'h12345678);
      check("mthi_lo_keep", lo2, 32'h1);
      a = 32'd5; b = 32'd6; start2 = 1'b1;
      step();
      wdata = 32'h0000DEAD; mthi2 = 1'b1; a = 32'd9; b = 32'd9;
      step();
      check("busy_mthi_hi", hi2, 32'h12345678);
      check("busy_start_x", mul_x2, 32'd5);
      check("busy_start_y", mul_y2, 32'd6);
      step();
      start2 = 1'b0; mthi2 = 1'b0;
      check("cap_over_mt_hi", hi2, 32'h0);
      check("cap_over_mt_lo", lo2, 32'd30);
      check("cap_over_mt_done", 32'(done2), 32'h1);
      step();
      check("no_restart_busy", 32'(busy2), 32'h0);

      // Simultaneous start + mtlo while idle.
      wdata = 32'd5; a = 32'd3; b = 32'd4; start2 = 1'b1; mtlo2 = 1'b1;
      step();
      start2 = 1'b0; mtlo2 = 1'b0;
      check("sim_lo_mt", lo2, 32'd5);
      check("sim_busy", 32'(busy2), 32'h1);
      step();
      step();
      check("sim_lo_prod", lo2, 32'd12);
      check("sim_done", 32'(done2), 32'h1);

      // Both mthi and mtlo in one idle cycle.
      wdata = 32'hAABBCCDD; mthi2 = 1'b1; mtlo2 = 1'b1;
      step();
      mthi2 = 1'b0; mtlo2 = 1'b0;
      check("both_hi", hi2, 32'hAABBCCDD);
      check("both_lo", lo2, 32'hAABBCCDD);

      // MUL_LAT=4: clear after edge 1 of a run aborts it.
      wdata = 32'h11111111; mthi4 = 1'b1; mtlo4 = 1'b1;
      step();
      mthi4 = 1'b0; mtlo4 = 1'b0;
      check("l4_pre_hi", hi4, 32'h11111111);
      a = 32'd3; b = 32'd4; start4 = 1'b1;
      step();
      start4 = 1'b0;
      step();
      clear4 = 1'b1;
      step();
      clear4 = 1'b0;
      check("l4_clr_hi", hi4, 32'h0);
      check("l4_clr_lo", lo4, 32'h0);
      check("l4_clr_busy", 32'(busy4), 32'h0);
      check("l4_clr_mul_x", mul_x4, 32'h0);
      for (int i = 0; i < 4; i++) begin
         step();
         check("l4_no_done", 32'(done4), 32'h0);
         check("l4_lo_hold", lo4, 32'h0);
      end
      a = 32'd6; b = 32'd7; start4 = 1'b1;
      step();
      start4 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("l4_busy_win", 32'(busy4), 32'h1);
         check("l4_done_win", 32'(done4), 32'h0);
      end
      step();
      check("l4_done", 32'(done4), 32'h1);
      check("l4_lo", lo4, 32'd42);
      check("l4_hi", hi4, 32'h0);
      check("l4_busy_end", 32'(busy4), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
